// File: rtl/fetch_sched.sv
// Two-wide instruction fetch scheduler: fetches up to two words per cycle
// into a circular queue and presents the oldest two entries to decode.
module fetch_sched #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 60,
    parameter int          QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_a1,
    output logic [31:0] imem_a2,
    input  logic [31:0] imem_rd1,
    input  logic [31:0] imem_rd2,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [1:0]  deq_cnt,
    output logic        out0_valid,
    output logic        out1_valid,
    output logic [31:0] out0_instr,
    output logic [31:0] out1_instr,
    output logic [31:0] out0_pc,
    output logic [31:0] out1_pc,
    output logic        done
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [32:0]   IMEM_END = 33'(IMEM_BYTES);
    localparam logic [CW-1:0] FILL_LIM = CW'(QDEPTH - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [31:0]   pc_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [31:0]   instr_q [QDEPTH];
    logic [31:0]   ipc_q   [QDEPTH];

    logic [31:0]   pc_next4_s;
    logic [31:0]   redir_pc_s;
    logic          pc_in_s;
    logic          pc4_in_s;
    logic          fetch_en_s;
    logic [1:0]    push_n_s;
    logic [1:0]    deq_req_s;
    logic [1:0]    deq_e_s;
    logic [CW-1:0] deq_ext_s;
    logic [CW-1:0] push_ext_s;
    logic [PW-1:0] head_p1_s;
    logic [PW-1:0] tail_p1_s;

    // Fetch enable, push/dequeue amounts and pointer arithmetic
    always_comb begin
        pc_next4_s = pc_r + 32'd4;
        redir_pc_s = redirect_pc & ~32'd3;
        pc_in_s    = ({1'b0, pc_r} < IMEM_END);
        pc4_in_s   = (({1'b0, pc_r} + 33'd4) < IMEM_END);
        // Registered count only: a same-cycle dequeue never opens room early.
        fetch_en_s = !redirect && pc_in_s && (count_r <= FILL_LIM);
        if (fetch_en_s) begin
            if (pc4_in_s) begin
                push_n_s = 2'd2;
            end else begin
                push_n_s = 2'd1;
            end
        end else begin
            push_n_s = 2'd0;
        end
        case (deq_cnt)
            2'd0:    deq_req_s = 2'd0;
            2'd1:    deq_req_s = 2'd1;
            default: deq_req_s = 2'd2;
        endcase
        if (CW'(deq_req_s) > count_r) begin
            deq_e_s = count_r[1:0];
        end else begin
            deq_e_s = deq_req_s;
        end
        deq_ext_s  = CW'(deq_e_s);
        push_ext_s = CW'(push_n_s);
        head_p1_s  = head_r + PTR_ONE;
        tail_p1_s  = tail_r + PTR_ONE;
    end

    // PC, occupancy and queue pointers; redirect outranks push and dequeue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            count_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
        end else if (redirect) begin
            pc_r    <= redir_pc_s;
            count_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            if (fetch_en_s) begin
                pc_r <= pc_r + {28'd0, push_n_s, 2'b00};
            end else begin
                pc_r <= pc_r;
            end
            count_r <= count_r - deq_ext_s + push_ext_s;
            head_r  <= head_r + PW'(deq_e_s);
            tail_r  <= tail_r + PW'(push_n_s);
        end
    end

    // Queue storage; contents are only meaningful below the valid count
    always_ff @(posedge clk) begin
        if (push_n_s != 2'd0) begin
            instr_q[tail_r] <= imem_rd1;
            ipc_q[tail_r]   <= pc_r;
        end
        if (push_n_s == 2'd2) begin
            instr_q[tail_p1_s] <= imem_rd2;
            ipc_q[tail_p1_s]   <= pc_next4_s;
        end
    end

    // Memory addresses and decode-facing view of the queue head
    always_comb begin
        imem_a1    = pc_r;
        imem_a2    = pc_next4_s;
        out0_valid = (count_r >= CNT_ONE);
        out1_valid = (count_r >= CNT_TWO);
        out0_instr = instr_q[head_r];
        out1_instr = instr_q[head_p1_s];
        out0_pc    = ipc_q[head_r];
        out1_pc    = ipc_q[head_p1_s];
        done       = !pc_in_s && (count_r == '0);
    end

    fetch_sched_chk #(
        .QDEPTH (QDEPTH)
    ) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .count  (count_r),
        .head   (head_r),
        .tail   (tail_r)
    );

endmodule

// Occupancy and pointer consistency properties for the fetch queue.
module fetch_sched_chk #(
    parameter int QDEPTH = 4
) (
    input logic                       clk,
    input logic                       rst_n,
    input logic [$clog2(QDEPTH):0]    count,
    input logic [$clog2(QDEPTH)-1:0]  head,
    input logic [$clog2(QDEPTH)-1:0]  tail
);

    localparam int PW = $clog2(QDEPTH);

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        count <= (PW + 1)'(QDEPTH));

    a_ptr_gap: assert property (@(posedge clk) disable iff (!rst_n)
        PW'(head + PW'(count)) == tail);

endmodule

// File: tb/tb_fetch_sched.sv
// Self-checking bench for fetch_sched: program-order scoreboard plus
// directed checks of reset, fill, redirect, underflow and async reset.
module tb_fetch_sched;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_a1, imem_a2, imem_rd1, imem_rd2;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  deq_cnt;
    logic        out0_valid, out1_valid;
    logic [31:0] out0_instr, out1_instr, out0_pc, out1_pc;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb [$];

    fetch_sched #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (60),
        .QDEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_a1     (imem_a1),
        .imem_a2     (imem_a2),
        .imem_rd1    (imem_rd1),
        .imem_rd2    (imem_rd2),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq_cnt     (deq_cnt),
        .out0_valid  (out0_valid),
        .out1_valid  (out1_valid),
        .out0_instr  (out0_instr),
        .out1_instr  (out1_instr),
        .out0_pc     (out0_pc),
        .out1_pc     (out1_pc),
        .done        (done)
    );

    assign imem_rd1 = 32'hA000_0000 | imem_a1;
    assign imem_rd2 = 32'hA000_0000 | imem_a2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expect program order from start to the end of memory, consume with dq.
    task automatic drain(input logic [31:0] start, input logic [1:0] dq);
        logic [31:0] e;
        int cycles;
        sb.delete();
        for (int a = int'(start); a < 60; a += 4) sb.push_back(32'(a));
        cycles = 0;
        while (sb.size() > 0 && cycles < 40) begin
            @(negedge clk);
            if (out0_valid) begin
                if (sb.size() == 1) check_eq("last_out1_valid", 32'(out1_valid), 32'd0);
                e = sb.pop_front();
                check_eq("out0_pc", out0_pc, e);
                check_eq("out0_instr", out0_instr, 32'hA000_0000 | e);
            end
            if (out1_valid) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("out1_pc", out1_pc, e);
                    check_eq("out1_instr", out1_instr, 32'hA000_0000 | e);
                end else begin
                    check_eq("extra_out1", 32'(out1_valid), 32'd0);
                end
            end
            deq_cnt = dq;
            cycles++;
        end
        check_eq("drain_left", 32'(sb.size()), 32'd0);
        @(negedge clk);
        deq_cnt = 2'd0;
        check_eq("done_after_drain", 32'(done), 32'd1);
        check_eq("empty_after_drain", 32'(out0_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        deq_cnt  = 2'd0;
        redirect = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        deq_cnt     = 2'd0;
        #2;
        check_eq("rst_out0_valid", 32'(out0_valid), 32'd0);
        check_eq("rst_out1_valid", 32'(out1_valid), 32'd0);
        check_eq("rst_imem_a1", imem_a1, 32'd0);
        check_eq("rst_imem_a2", imem_a2, 32'd4);
        check_eq("rst_done", 32'(done), 32'd0);

        // Fill with no dequeue
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("fill1_out0_instr", out0_instr, 32'hA000_0000);
        check_eq("fill1_out0_pc", out0_pc, 32'd0);
        check_eq("fill1_out1_instr", out1_instr, 32'hA000_0004);
        check_eq("fill1_out1_pc", out1_pc, 32'd4);
        check_eq("fill1_out1_valid", 32'(out1_valid), 32'd1);
        @(negedge clk);
        check_eq("fill2_imem_a1", imem_a1, 32'd16);
        @(negedge clk);
        check_eq("full_imem_a1", imem_a1, 32'd16);
        check_eq("full_out0_pc", out0_pc, 32'd0);

        // Steady two-wide drain to the end of the program
        drain(32'd0, 2'd2);

        // Queue holding 8..20, then redirect to an unaligned target
        do_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        deq_cnt = 2'd2;
        @(negedge clk);
        deq_cnt = 2'd0;
        @(negedge clk);
        check_eq("pre_redir_out0_pc", out0_pc, 32'd8);
        check_eq("pre_redir_out1_pc", out1_pc, 32'd12);
        check_eq("pre_redir_imem_a1", imem_a1, 32'd24);
        redirect    = 1'b1;
        redirect_pc = 32'h23;
        deq_cnt     = 2'd2;
        @(negedge clk);
        redirect = 1'b0;
        deq_cnt  = 2'd0;
        check_eq("redir_out0_valid", 32'(out0_valid), 32'd0);
        check_eq("redir_imem_a1", imem_a1, 32'h20);
        @(negedge clk);
        check_eq("redir_out0_pc", out0_pc, 32'd32);
        check_eq("redir_out1_pc", out1_pc, 32'd36);
        check_eq("redir_out0_instr", out0_instr, 32'hA000_0020);

        // Single last word, then over-request against count 1
        redirect    = 1'b1;
        redirect_pc = 32'd56;
        @(negedge clk);
        redirect = 1'b0;
        check_eq("r56_out0_valid", 32'(out0_valid), 32'd0);
        @(negedge clk);
        check_eq("one_out0_valid", 32'(out0_valid), 32'd1);
        check_eq("one_out0_pc", out0_pc, 32'd56);
        check_eq("one_out1_valid", 32'(out1_valid), 32'd0);
        check_eq("one_imem_a1", imem_a1, 32'd60);
        check_eq("one_done", 32'(done), 32'd0);
        deq_cnt = 2'd2;
        @(negedge clk);
        check_eq("underflow_valid", 32'(out0_valid), 32'd0);
        check_eq("underflow_done", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("underflow_valid2", 32'(out0_valid), 32'd0);
        deq_cnt = 2'd0;

        // Redirect beyond the program
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        check_eq("far_done", 32'(done), 32'd1);
        check_eq("far_imem_a1", imem_a1, 32'h100);
        @(negedge clk);
        check_eq("far_done_hold", 32'(done), 32'd1);
        check_eq("far_out0_valid", 32'(out0_valid), 32'd0);

        // Restart at 0, then an asynchronous reset pulse between edges
        redirect    = 1'b1;
        redirect_pc = 32'd0;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_out1_valid", 32'(out1_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_out0_valid", 32'(out0_valid), 32'd0);
        check_eq("async_out1_valid", 32'(out1_valid), 32'd0);
        check_eq("async_imem_a1", imem_a1, 32'd0);
        #2;
        rst_n = 1'b1;
        drain(32'd0, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_sched.md
FETCH_SCHED -- requirements
Module: fetch_sched

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded at reset.
REQ-002 Parameter IMEM_BYTES, default 60: program size in bytes; fetch stops at or beyond this address.
REQ-003 Parameter QDEPTH, default 4: instruction queue entries; power of two, at least 4.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 imem_a1  output  32: byte address to inst_memory port A1; equals the PC register.
REQ-007 imem_a2  output  32: byte address to inst_memory port A2; equals PC+4.
REQ-008 imem_rd1  input  32: instruction word at imem_a1, read combinationally in the same cycle.
REQ-009 imem_rd2  input  32: instruction word at imem_a2, read combinationally in the same cycle.
REQ-010 redirect  input  1: branch/jump taken; flush the queue and refetch.
REQ-011 redirect_pc  input  32: target byte address for a redirect.
REQ-012 deq_cnt  input  2: number of instructions decode consumes this cycle (0, 1 or 2).
REQ-013 out0_valid, out1_valid  output  1 each: queue head and head+1 hold valid instructions.
REQ-014 out0_instr, out1_instr  output  32 each: instruction words at head and head+1.
REQ-015 out0_pc, out1_pc  output  32 each: byte addresses of those instructions.
REQ-016 done  output  1: program exhausted and queue empty.

Function
REQ-017 fetch_en = !redirect && (PC < IMEM_BYTES) && (count <= QDEPTH-2); it uses the registered count and never bypasses the same-cycle dequeue.
REQ-018 Push count when fetch_en: 2 if PC+4 < IMEM_BYTES, else 1; push_n is 0 when fetch_en is low.
REQ-019 Pushed entries: {imem_rd1, PC} at the tail, then {imem_rd2, PC+4} at tail+1 when push_n is 2.
REQ-020 PC update when fetch_en: PC <= PC + 4*push_n; otherwise PC holds, unless REQ-024 applies.
REQ-021 Effective dequeue deq_e = min(deq_cnt, count); a deq_cnt of 3 is treated as 2; an over-request never underflows the queue.
REQ-022 count <= count - deq_e + push_n; the head pointer advances by deq_e, the tail pointer by push_n; both wrap modulo QDEPTH.
REQ-023 Combinational outputs: out0_valid = (count >= 1), out1_valid = (count >= 2); instr and pc outputs are don't-care when the matching valid is low.
REQ-024 Redirect has priority over push and dequeue in the same cycle: count <= 0, head and tail pointers <= 0, PC <= redirect_pc with bits [1:0] cleared.
REQ-025 A redirect to an address >= IMEM_BYTES is legal: the queue empties, fetch stays off, and done rises the next cycle.
REQ-026 done = (PC >= IMEM_BYTES) && (count == 0), combinational.
REQ-027 Latency: an instruction read in cycle N is visible on out0/out1 in cycle N+1.
REQ-028 Simultaneous dequeue of 2 and push of 2 at count 2 leaves count at 2 with pointers wrapped correctly.
REQ-029 A full queue (count = QDEPTH) holds its contents; fetch is off and PC is stable.

Reset
REQ-030 While rst_n is low: PC = RESET_PC, count = 0, head = 0, tail = 0; out0_valid = out1_valid = 0; imem_a1 = RESET_PC, imem_a2 = RESET_PC+4.
REQ-031 Assertion of rst_n mid-operation discards all queued instructions immediately, without waiting for a clock edge.
REQ-032 Queue storage is not reset; only the valid state derived from count is defined.
REQ-033 The first fetch occurs on the first rising edge after rst_n is released.

Verification
REQ-034 Bench memory model returns word = 32'hA000_0000 | address for both ports, with IMEM_BYTES = 60.
REQ-035 Reset release, deq_cnt = 0 -> after edge 1: out0 = A0000000/pc 0, out1 = A0000004/pc 4; after edge 2: count 4, PC 16; fetch then stops with imem_a1 held at 16.
REQ-036 Steady state, deq_cnt = 2 every cycle -> two instructions per cycle in order 0, 4, 8, ...; the last cycle delivers only out0 = A0000038 (pc 56); done = 1 afterwards.
REQ-037 Queue holding pcs 8..20 with redirect = 1, redirect_pc = 32'h23, deq_cnt = 2 -> next cycle count 0, imem_a1 = 32 (0x20); the cycle after that, out0 pc = 32 and out1 pc = 36.
REQ-038 count = 1, deq_cnt = 2 -> only 1 entry is removed, no underflow; count equals push_n the next cycle.
REQ-039 rst_n pulsed low for 3 ns mid-stream with no clock edge -> outputs show zero valid immediately; after release the fetch sequence restarts from pc 0.
